// File: rtl/sprite_attr_engine.sv
// Sprite/UI command decoder: turns 24-bit CPU commands into single-word memory writes,
// keeps per-sprite attribute shadows, and sequences a multi-cycle clear of all attribute words.
module sprite_attr_engine #(
  parameter int SPR_W    = 5,
  parameter int TEX_W    = 5,
  parameter int TEX_BASE = 8,
  parameter int UI_W     = 4,
  parameter int ADDR_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [23:0]       in,
  output logic              wx,
  output logic [ADDR_W-1:0] waddrx,
  output logic [31:0]       savex,
  output logic              rdy,
  output logic              busy
);

  localparam int unsigned NSPR = 1 << SPR_W;
  localparam int unsigned NCLR = 1 << (SPR_W + 1);

  localparam logic [7:0] OP_UI_TEX   = 8'd15;
  localparam logic [7:0] OP_UI_LINE  = 8'd16;
  localparam logic [7:0] OP_UI_PIX   = 8'd17;
  localparam logic [7:0] OP_SP_TEX   = 8'd18;
  localparam logic [7:0] OP_SP_LINE  = 8'd19;
  localparam logic [7:0] OP_SP_PIX1  = 8'd20;
  localparam logic [7:0] OP_SP_PIX2  = 8'd21;
  localparam logic [7:0] OP_SEL      = 8'd22;
  localparam logic [7:0] OP_POSX     = 8'd23;
  localparam logic [7:0] OP_POSY     = 8'd24;
  localparam logic [7:0] OP_SCLX     = 8'd25;
  localparam logic [7:0] OP_SCLY     = 8'd26;
  localparam logic [7:0] OP_SWPX     = 8'd27;
  localparam logic [7:0] OP_SWPY     = 8'd28;
  localparam logic [7:0] OP_CLR_A    = 8'd29;
  localparam logic [7:0] OP_TEX      = 8'd30;
  localparam logic [7:0] OP_COL1     = 8'd31;
  localparam logic [7:0] OP_COL2     = 8'd32;
  localparam logic [7:0] OP_COL3     = 8'd33;
  localparam logic [7:0] OP_COL4     = 8'd34;
  localparam logic [7:0] OP_CLR_B    = 8'd35;
  localparam logic [7:0] OP_ZERO     = 8'd249;
  localparam logic [7:0] OP_CLR_ALL  = 8'd250;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e              state_q, state_d;
  logic [SPR_W:0]      clr_q, clr_d;
  logic [UI_W-1:0]     ui_tex_q, ui_tex_d;
  logic [2:0]          ui_line_q, ui_line_d;
  logic [15:0]         ui_latch_q, ui_latch_d;
  logic [TEX_W-1:0]    spr_tex_q, spr_tex_d;
  logic [3:0]          spr_line_q, spr_line_d;
  logic [15:0]         pix1_q, pix1_d;
  logic [SPR_W-1:0]    spr_sel_q, spr_sel_d;
  logic [31:0]         shad_a_q [NSPR];
  logic [31:0]         shad_a_d [NSPR];
  logic [31:0]         shad_b_q [NSPR];
  logic [31:0]         shad_b_d [NSPR];
  logic                wx_q, wx_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         savex_q, savex_d;
  logic                rdy_q, rdy_d;

  logic [7:0]          opcode;
  logic [15:0]         data;
  logic [ADDR_W-1:0]   zaddr;
  logic [31:0]         word_a, word_b;
  logic                wr_a, wr_b;

  assign opcode = in[23:16];
  assign data   = in[15:0];
  assign zaddr  = in[ADDR_W-1:0];

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    ui_tex_d   = ui_tex_q;
    ui_line_d  = ui_line_q;
    ui_latch_d = ui_latch_q;
    spr_tex_d  = spr_tex_q;
    spr_line_d = spr_line_q;
    pix1_d     = pix1_q;
    spr_sel_d  = spr_sel_q;
    shad_a_d   = shad_a_q;
    shad_b_d   = shad_b_q;
    wx_d       = 1'b0;
    waddr_d    = '0;
    savex_d    = '0;
    rdy_d      = 1'b0;
    word_a     = shad_a_q[spr_sel_q];
    word_b     = shad_b_q[spr_sel_q];
    wr_a       = 1'b0;
    wr_b       = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        // clr_q wraps to zero once the last address has been written
        if (clr_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          wx_d    = 1'b1;
          waddr_d = ADDR_W'(clr_q);
          clr_d   = clr_q + 1'b1;
          rdy_d   = &clr_q;
          if (clr_q[0]) shad_b_d[clr_q[SPR_W:1]] = '0;
          else          shad_a_d[clr_q[SPR_W:1]] = '0;
        end
      end
      default: begin
        if (start) begin
          rdy_d = 1'b1;
          case (opcode)
            OP_UI_TEX:  ui_tex_d  = data[UI_W-1:0];
            OP_UI_LINE: ui_line_d = data[2:0];
            OP_UI_PIX: begin
              if (!ui_line_q[0]) begin
                ui_latch_d = data;
              end else begin
                wx_d    = 1'b1;
                waddr_d = ADDR_W'({1'b1, ui_tex_q, ui_line_q[2:1]});
                savex_d = {ui_latch_q, data};
              end
            end
            OP_SP_TEX: begin
              if (data[TEX_W-1:0] >= TEX_W'(TEX_BASE)) spr_tex_d = data[TEX_W-1:0];
            end
            OP_SP_LINE: spr_line_d = data[3:0];
            OP_SP_PIX1: pix1_d     = data;
            OP_SP_PIX2: begin
              wx_d    = 1'b1;
              waddr_d = ADDR_W'({spr_tex_q, spr_line_q});
              savex_d = {pix1_q, data};
            end
            OP_SEL:  spr_sel_d = data[SPR_W-1:0];
            OP_POSX: begin word_a[31:23] = data[8:0]; wr_a = 1'b1; end
            OP_POSY: begin word_a[22:15] = data[7:0]; wr_a = 1'b1; end
            OP_SCLX: begin word_a[14:11] = data[3:0]; wr_a = 1'b1; end
            OP_SCLY: begin word_a[10:7]  = data[3:0]; wr_a = 1'b1; end
            OP_SWPX: begin word_a[6]     = data[0];   wr_a = 1'b1; end
            OP_SWPY: begin word_a[5]     = data[0];   wr_a = 1'b1; end
            OP_CLR_A: begin word_a = '0; wr_a = 1'b1; end
            OP_TEX: begin
              word_b[31]    = 1'b0;
              word_b[30:26] = data[4:0];
              wr_b          = 1'b1;
            end
            OP_COL1: begin word_b[25:21] = data[4:0]; wr_b = 1'b1; end
            OP_COL2: begin word_b[20:16] = data[4:0]; wr_b = 1'b1; end
            OP_COL3: begin word_b[15:11] = data[4:0]; wr_b = 1'b1; end
            OP_COL4: begin word_b[10:6]  = data[4:0]; wr_b = 1'b1; end
            OP_CLR_B: begin word_b = '0; wr_b = 1'b1; end
            OP_ZERO: begin
              wx_d    = 1'b1;
              waddr_d = zaddr;
              if ({1'b0, zaddr} < (ADDR_W + 1)'(NCLR)) begin
                if (zaddr[0]) shad_b_d[zaddr[SPR_W:1]] = '0;
                else          shad_a_d[zaddr[SPR_W:1]] = '0;
              end
            end
            OP_CLR_ALL: begin
              // address 0 is written on the accept edge; the counter covers the rest
              state_d     = ST_CLEAR;
              clr_d       = (SPR_W + 1)'(1);
              wx_d        = 1'b1;
              waddr_d     = '0;
              rdy_d       = 1'b0;
              shad_a_d[0] = '0;
            end
            default: ;
          endcase

          if (wr_a) begin
            shad_a_d[spr_sel_q] = word_a;
            wx_d    = 1'b1;
            waddr_d = ADDR_W'({spr_sel_q, 1'b0});
            savex_d = word_a;
          end
          if (wr_b) begin
            shad_b_d[spr_sel_q] = word_b;
            wx_d    = 1'b1;
            waddr_d = ADDR_W'({spr_sel_q, 1'b1});
            savex_d = word_b;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      clr_q      <= '0;
      ui_tex_q   <= '0;
      ui_line_q  <= '0;
      ui_latch_q <= '0;
      spr_tex_q  <= '0;
      spr_line_q <= '0;
      pix1_q     <= '0;
      spr_sel_q  <= '0;
      for (int unsigned i = 0; i < NSPR; i++) begin
        shad_a_q[i] <= '0;
        shad_b_q[i] <= '0;
      end
      wx_q       <= 1'b0;
      waddr_q    <= '0;
      savex_q    <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      ui_tex_q   <= ui_tex_d;
      ui_line_q  <= ui_line_d;
      ui_latch_q <= ui_latch_d;
      spr_tex_q  <= spr_tex_d;
      spr_line_q <= spr_line_d;
      pix1_q     <= pix1_d;
      spr_sel_q  <= spr_sel_d;
      shad_a_q   <= shad_a_d;
      shad_b_q   <= shad_b_d;
      wx_q       <= wx_d;
      waddr_q    <= waddr_d;
      savex_q    <= savex_d;
      rdy_q      <= rdy_d;
    end
  end

  assign wx     = wx_q;
  assign waddrx = waddr_q;
  assign savex  = savex_q;
  assign rdy    = rdy_q;
  assign busy   = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_sprite_attr_engine.sv
// Scoreboard bench for sprite_attr_engine: a field-level reference model queues expected
// output cycles; a negedge monitor pops and compares whenever wx or rdy is high.
module tb_sprite_attr_engine;
  localparam int SPR_W = 5, TEX_W = 5, TEX_BASE = 8, UI_W = 4, ADDR_W = 9;
  localparam int NSPR = 1 << SPR_W;
  localparam int NCLR = 1 << (SPR_W + 1);

  logic              clk = 1'b0;
  logic              rst, start;
  logic [23:0]       cmd;
  logic              wx, rdy, busy;
  logic [ADDR_W-1:0] waddrx;
  logic [31:0]       savex;

  sprite_attr_engine #(.SPR_W(SPR_W), .TEX_W(TEX_W), .TEX_BASE(TEX_BASE),
                       .UI_W(UI_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in(cmd), .wx(wx),
    .waddrx(waddrx), .savex(savex), .rdy(rdy), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    int unsigned addr;
    logic [31:0] data;
    bit          rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // reference model: selections and per-sprite attribute fields as plain integers
  int unsigned m_ui_tex, m_ui_line, m_ui_latch, m_tex, m_line, m_pix1, m_sel;
  int unsigned m_posx[NSPR], m_posy[NSPR], m_sclx[NSPR], m_scly[NSPR];
  int unsigned m_swpx[NSPR], m_swpy[NSPR];
  int unsigned m_stex[NSPR], m_c1[NSPR], m_c2[NSPR], m_c3[NSPR], m_c4[NSPR];

  function automatic logic [31:0] word_a(int unsigned s);
    return 32'(m_posx[s] * (2 ** 23) + m_posy[s] * (2 ** 15) + m_sclx[s] * (2 ** 11)
             + m_scly[s] * (2 ** 7) + m_swpx[s] * 64 + m_swpy[s] * 32);
  endfunction

  function automatic logic [31:0] word_b(int unsigned s);
    return 32'(m_stex[s] * (2 ** 26) + m_c1[s] * (2 ** 21) + m_c2[s] * (2 ** 16)
             + m_c3[s] * (2 ** 11) + m_c4[s] * 64);
  endfunction

  function automatic void zero_word(int unsigned a);
    int unsigned s = a / 2;
    if (a % 2 == 0) begin
      m_posx[s] = 0; m_posy[s] = 0; m_sclx[s] = 0; m_scly[s] = 0; m_swpx[s] = 0; m_swpy[s] = 0;
    end else begin
      m_stex[s] = 0; m_c1[s] = 0; m_c2[s] = 0; m_c3[s] = 0; m_c4[s] = 0;
    end
  endfunction

  function automatic void model_reset();
    m_ui_tex = 0; m_ui_line = 0; m_ui_latch = 0; m_tex = 0; m_line = 0; m_pix1 = 0; m_sel = 0;
    for (int a = 0; a < NCLR; a++) zero_word(a);
  endfunction

  function automatic void push(bit en, bit w, int unsigned a, logic [31:0] d, bit r);
    exp_t e;
    if (!en) return;
    e.w = w; e.addr = a; e.data = d; e.rdy = r;
    exp_q.push_back(e);
  endfunction

  function automatic void model_cmd(int unsigned op, int unsigned d, bit en);
    int unsigned s = m_sel;
    int unsigned a;
    case (op)
      15: begin m_ui_tex = d % (1 << UI_W); push(en, 0, 0, 0, 1); end
      16: begin m_ui_line = d % 8; push(en, 0, 0, 0, 1); end
      17: begin
        if (m_ui_line % 2 == 1)
          push(en, 1, (1 << (UI_W + 2)) + m_ui_tex * 4 + m_ui_line / 2,
               32'(m_ui_latch * 65536 + d), 1);
        else begin
          m_ui_latch = d; push(en, 0, 0, 0, 1);
        end
      end
      18: begin
        if (d % (1 << TEX_W) >= TEX_BASE) m_tex = d % (1 << TEX_W);
        push(en, 0, 0, 0, 1);
      end
      19: begin m_line = d % 16; push(en, 0, 0, 0, 1); end
      20: begin m_pix1 = d; push(en, 0, 0, 0, 1); end
      21: push(en, 1, m_tex * 16 + m_line, 32'(m_pix1 * 65536 + d), 1);
      22: begin m_sel = d % NSPR; push(en, 0, 0, 0, 1); end
      23, 24, 25, 26, 27, 28, 29: begin
        case (op)
          23: m_posx[s] = d % 512;
          24: m_posy[s] = d % 256;
          25: m_sclx[s] = d % 16;
          26: m_scly[s] = d % 16;
          27: m_swpx[s] = d % 2;
          28: m_swpy[s] = d % 2;
          default: zero_word(2 * s);
        endcase
        push(en, 1, 2 * s, word_a(s), 1);
      end
      30, 31, 32, 33, 34, 35: begin
        case (op)
          30: m_stex[s] = d % 32;
          31: m_c1[s] = d % 32;
          32: m_c2[s] = d % 32;
          33: m_c3[s] = d % 32;
          34: m_c4[s] = d % 32;
          default: zero_word(2 * s + 1);
        endcase
        push(en, 1, 2 * s + 1, word_b(s), 1);
      end
      249: begin
        a = d % (1 << ADDR_W);
        push(en, 1, a, 0, 1);
        if (a < NCLR) zero_word(a);
      end
      250: begin
        for (int i = 0; i < NCLR; i++) begin
          push(en, 1, i, 0, i == NCLR - 1);
          zero_word(i);
        end
      end
      default: push(en, 0, 0, 0, 1);
    endcase
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  task automatic drive(input int unsigned op, input int unsigned d);
    cmd = {op[7:0], d[15:0]};
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic issue(input int unsigned op, input int unsigned d);
    model_cmd(op, d, 1'b1);
    drive(op, d);
  endtask

  // model state still advances, but the queued expectation is the literal given here
  task automatic issue_x(input int unsigned op, input int unsigned d, input bit w,
                         input int unsigned a, input logic [31:0] data);
    model_cmd(op, d, 1'b0);
    push(1'b1, w, a, data, 1'b1);
    drive(op, d);
  endtask

  task automatic do_clear(input bit poke);
    issue(250, $urandom_range(0, 65535));
    for (int i = 0; i < NCLR; i++) begin
      @(negedge clk);
      check("busy_during_clear", {31'b0, busy}, 1);
      if (poke && i == 5) begin
        cmd = {8'd23, 16'h01FF};
        start = 1'b1;
      end
      if (poke && i == 40) start = 1'b0;
    end
    @(negedge clk);
    check("busy_after_clear", {31'b0, busy}, 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (wx || rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got wx=%0b addr=%0h data=%08h rdy=%0b expected no output",
                 wx, waddrx, savex, rdy);
      end else begin
        mon_e = exp_q.pop_front();
        if (wx !== mon_e.w || waddrx !== ADDR_W'(mon_e.addr) || savex !== mon_e.data ||
            rdy !== mon_e.rdy) begin
          failures++;
          $display("FAIL write_cycle: got wx=%0b addr=%0h data=%08h rdy=%0b expected wx=%0b addr=%0h data=%08h rdy=%0b",
                   wx, waddrx, savex, rdy, mon_e.w, mon_e.addr, mon_e.data, mon_e.rdy);
        end
      end
    end
  end

  initial begin
    int unsigned op, d, r;
    rst = 1'b1; start = 1'b0; cmd = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_wx", {31'b0, wx}, 0);
    check("reset_waddrx", 32'(waddrx), 0);
    check("reset_savex", savex, 0);
    check("reset_rdy", {31'b0, rdy}, 0);
    check("reset_busy", {31'b0, busy}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // select sprite 3, set position: read-modify-write of word A
    issue_x(22, 3, 0, 0, 0);
    issue_x(23, 'h12C, 1, 6, 32'h96000000);
    issue_x(24, 'h50, 1, 6, 32'h96280000);

    // shadow retained across reselect
    issue_x(29, 0, 1, 6, 32'h0);
    issue_x(23, 'h12C, 1, 6, 32'h96000000);
    issue_x(22, 4, 0, 0, 0);
    issue_x(31, 7, 1, 9, 32'h00E00000);
    issue_x(22, 3, 0, 0, 0);
    issue_x(27, 1, 1, 6, 32'h96000040);

    // sprite texture below TEX_BASE is rejected
    issue_x(18, 9, 0, 0, 0);
    issue_x(18, 3, 0, 0, 0);
    issue_x(19, 2, 0, 0, 0);
    issue_x(20, 'hAAAA, 0, 0, 0);
    issue_x(21, 'h5555, 1, 'h92, 32'hAAAA5555);

    // UI write: {1, tex=2, line[2:1]=0} -> 7'b1_0010_00 = 0x48
    issue_x(15, 2, 0, 0, 0);
    issue_x(16, 0, 0, 0, 0);
    issue_x(17, 'h1234, 0, 0, 0);
    issue_x(16, 1, 0, 0, 0);
    issue_x(17, 'hABCD, 1, 'h48, 32'h1234ABCD);

    // direct zero of an attribute word also clears its shadow
    issue_x(30, 1, 1, 7, 32'h04000000);
    issue_x(249, 7, 1, 7, 32'h0);
    issue_x(32, 5, 1, 7, 32'h00050000);
    issue_x(8, 0, 0, 0, 0);

    do_clear(1'b1);
    issue_x(22, 3, 0, 0, 0);
    issue_x(23, 1, 1, 6, 32'h00800000);

    // reset in the middle of clear-all
    issue(22, 5);
    issue(31, 9);
    issue(250, 0);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    check("midclear_rst_wx", {31'b0, wx}, 0);
    check("midclear_rst_busy", {31'b0, busy}, 0);
    issue_x(23, 'h12C, 1, 0, 32'h96000000);
    issue_x(22, 5, 0, 0, 0);
    issue_x(33, 1, 1, 11, 32'h00000800);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      d = $urandom_range(0, 65535);
      if (r < 88) op = 15 + $urandom_range(0, 20);
      else if (r < 94) begin
        op = 249;
        if ($urandom_range(0, 1) == 1) d = $urandom_range(0, NCLR - 1);
      end else if (r < 98) op = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 14)
                                                          : $urandom_range(36, 248);
      else op = 250;
      if (op == 18 && $urandom_range(0, 1) == 1) d = $urandom_range(0, 31);
      if (op == 250) do_clear(1'b0);
      else issue(op, d);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
